// File: rtl/bus_pkg.sv
// Shared encodings for the memory bus fabric: FSM states, error codes and
// the widths of the latched slave index and the select-cycle counter.
package bus_pkg;

    localparam int IDX_W = 3;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_code_e;

endpackage

// File: rtl/addr_decode.sv
// Combinational base/mask address matcher; the lowest-numbered matching
// slave wins and is reported both one-hot and as a binary index.
module addr_decode
    import bus_pkg::*;
#(
    parameter int                       NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE   = '0,
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK   = '0
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] onehot,
    output logic [IDX_W-1:0]      idx
);

    always_comb begin
        hit    = 1'b0;
        onehot = '0;
        idx    = '0;
        // Walk from the top down so a lower-index match overrides a higher one.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit    = 1'b1;
                onehot = NUM_SLAVES'(1) << i;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-master to multi-slave memory bus fabric with address decode,
// wait-state tracking, timeout and unmapped-access error termination.
module mem_bus_fabric
    import bus_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE       = {32'h8000_0010, 32'h8000_0008,
                                                          32'h8000_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK       = {32'hFFFF_FFFF, 32'hFFFF_FFF8,
                                                          32'hFFFF_FFFF, 32'hFFFF_E000},
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_valid,
    input  logic [31:0]                mem_addr,
    input  logic [3:0]                 mem_wstrb,
    output logic                       mem_ready,
    output logic [31:0]                mem_rdata,
    output logic [NUM_SLAVES-1:0]      slv_sel,
    input  logic [NUM_SLAVES-1:0]      slv_ready,
    input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
    output logic                       err_irq,
    output logic [1:0]                 err_type,
    output logic [31:0]                err_addr,
    output logic [7:0]                 err_count
);

    state_e                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        lat_idx, lat_idx_n;
    err_code_e               err_type_q, err_code_n;
    logic [31:0]             err_addr_q;
    logic [7:0]              err_count_q;
    logic                    err_irq_q;
    logic                    err_enter;

    logic                    dec_hit;
    logic [NUM_SLAVES-1:0]   dec_oh;
    logic [IDX_W-1:0]        dec_idx;
    logic [NUM_SLAVES-1:0]   lat_oh;
    logic [NUM_SLAVES-1:0]   sel_c;
    logic                    ready_c;
    logic                    use_err_c;
    logic [32*NUM_SLAVES-1:0] rd_masked;
    logic [31:0]             rdata_c;

    // Byte enables do not affect routing; writes and reads decode identically.
    logic wstrb_unused;
    assign wstrb_unused = |mem_wstrb;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_addr_decode (
        .addr   (mem_addr),
        .hit    (dec_hit),
        .onehot (dec_oh),
        .idx    (dec_idx)
    );

    genvar g;
    generate
        for (g = 0; g < NUM_SLAVES; g++) begin : g_slave
            assign lat_oh[g]              = (lat_idx == IDX_W'(g));
            assign rd_masked[32*g +: 32]  = slv_rdata[32*g +: 32] & {32{sel_c[g]}};
        end
    endgenerate

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lat_idx_n  = lat_idx;
        err_enter  = 1'b0;
        err_code_n = ERR_NONE;
        sel_c      = '0;
        ready_c    = 1'b0;
        use_err_c  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (dec_hit) begin
                        sel_c   = dec_oh;
                        ready_c = |(slv_ready & dec_oh);
                        if (!ready_c) begin
                            state_n   = WAIT;
                            lat_idx_n = dec_idx;
                            cnt_n     = CNT_W'(1);
                        end
                    end else begin
                        state_n    = ERR;
                        err_enter  = 1'b1;
                        err_code_n = ERR_UNMAPPED;
                    end
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    sel_c   = lat_oh;
                    ready_c = |(slv_ready & lat_oh);
                    if (ready_c) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // The IDLE cycle plus TIMEOUT_CYCLES-1 WAIT cycles already selected.
                        state_n    = ERR;
                        cnt_n      = '0;
                        err_enter  = 1'b1;
                        err_code_n = ERR_TIMEOUT;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            ERR: begin
                ready_c   = 1'b1;
                use_err_c = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (reset) begin
            sel_c     = '0;
            ready_c   = 1'b0;
            use_err_c = 1'b0;
        end
    end

    always_comb begin
        rdata_c = '0;
        if (use_err_c) begin
            rdata_c = ERR_RDATA;
        end else if (ready_c) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                rdata_c = rdata_c | rd_masked[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_idx     <= '0;
            err_type_q  <= ERR_NONE;
            err_addr_q  <= '0;
            err_count_q <= '0;
            err_irq_q   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lat_idx   <= lat_idx_n;
            err_irq_q <= err_enter;
            if (err_enter) begin
                err_type_q  <= err_code_n;
                err_addr_q  <= mem_addr;
                err_count_q <= sat_inc8(err_count_q);
            end
        end
    end

    assign slv_sel   = sel_c;
    assign mem_ready = ready_c;
    assign mem_rdata = rdata_c;
    assign err_irq   = err_irq_q;
    assign err_type  = err_type_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric with four slaves and an 8-cycle timeout.
module tb_mem_bus_fabric;

    logic         clk;
    logic         reset;
    logic         mem_valid;
    logic [31:0]  mem_addr;
    logic [3:0]   mem_wstrb;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [3:0]   slv_sel;
    logic [3:0]   slv_ready;
    logic [127:0] slv_rdata;
    logic         err_irq;
    logic [1:0]   err_type;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;

    mem_bus_fabric #(
        .NUM_SLAVES     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .slv_sel   (slv_sel),
        .slv_ready (slv_ready),
        .slv_rdata (slv_rdata),
        .err_irq   (err_irq),
        .err_type  (err_type),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        slv_ready = '0;
        slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};
        step();
        step();

        // Outputs held quiet while reset is asserted, even with a live request.
        mem_valid = 1'b1; mem_addr = 32'h0000_0100; slv_ready = 4'b0001;
        #1;
        chk("rst_sel", slv_sel, 32'h0);
        chk("rst_ready", mem_ready, 32'h0);
        step();
        reset = 1'b0; mem_valid = 1'b0; slv_ready = 4'b0000;
        #1;
        chk("rst_err_type", err_type, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_err_count", err_count, 32'h0);
        chk("rst_err_irq", err_irq, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);

        // Zero-latency hit on slave 0.
        mem_valid = 1'b1; mem_addr = 32'h0000_0100; slv_ready = 4'b0001;
        #1;
        chk("t1_sel", slv_sel, 32'h1);
        chk("t1_ready", mem_ready, 32'h1);
        chk("t1_rdata", mem_rdata, 32'h1234_5678);
        step();
        mem_valid = 1'b0; slv_ready = 4'b0000;
        #1;
        chk("t1_idle_ready", mem_ready, 32'h0);
        chk("t1_idle_rdata", mem_rdata, 32'h0);

        // Ready from non-selected slaves is ignored; latched slave completes next cycle.
        mem_valid = 1'b1; mem_addr = 32'h0000_0100; slv_ready = 4'b1110;
        #1;
        chk("ign_sel", slv_sel, 32'h1);
        chk("ign_ready", mem_ready, 32'h0);
        step();
        slv_ready = 4'b0001;
        #1;
        chk("ign_wait_ready", mem_ready, 32'h1);
        chk("ign_wait_rdata", mem_rdata, 32'h1234_5678);
        step();
        mem_valid = 1'b0; slv_ready = 4'b0000;

        // Slave 2 with three wait states.
        mem_valid = 1'b1; mem_addr = 32'h8000_000C;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t2_sel", slv_sel, 32'h4);
            chk("t2_ready", mem_ready, 32'h0);
            step();
        end
        slv_ready = 4'b0100;
        #1;
        chk("t2_sel_last", slv_sel, 32'h4);
        chk("t2_ready_last", mem_ready, 32'h1);
        chk("t2_rdata", mem_rdata, 32'h2222_2222);
        step();
        mem_valid = 1'b0; slv_ready = 4'b0000;
        #1;
        chk("t2_after_ready", mem_ready, 32'h0);
        chk("t2_no_err", err_count, 32'h0);
        chk("t2_no_irq", err_irq, 32'h0);

        // Abandoned request in WAIT returns to IDLE without error.
        mem_valid = 1'b1; mem_addr = 32'h8000_000C;
        step();
        mem_valid = 1'b0;
        #1;
        chk("abn_sel", slv_sel, 32'h0);
        chk("abn_ready", mem_ready, 32'h0);
        step();
        mem_valid = 1'b1; mem_addr = 32'h0000_0100; slv_ready = 4'b0001;
        #1;
        chk("abn_idle_sel", slv_sel, 32'h1);
        chk("abn_idle_ready", mem_ready, 32'h1);
        chk("abn_irq", err_irq, 32'h0);
        step();
        mem_valid = 1'b0; slv_ready = 4'b0000;

        // Unmapped write is dropped and terminated with an error cycle.
        mem_valid = 1'b1; mem_addr = 32'h4000_0000; mem_wstrb = 4'hF; slv_ready = 4'b1111;
        #1;
        chk("t3_sel0", slv_sel, 32'h0);
        chk("t3_ready0", mem_ready, 32'h0);
        step();
        chk("t3_sel1", slv_sel, 32'h0);
        chk("t3_ready1", mem_ready, 32'h1);
        chk("t3_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("t3_irq", err_irq, 32'h1);
        chk("t3_type", err_type, 32'h1);
        chk("t3_addr", err_addr, 32'h4000_0000);
        chk("t3_count", err_count, 32'h1);
        mem_valid = 1'b0; mem_wstrb = 4'h0; slv_ready = 4'b0000;
        step();
        chk("t3_irq_pulse", err_irq, 32'h0);
        chk("t3_ready_off", mem_ready, 32'h0);

        // Timeout on slave 3: eight select cycles then the error cycle.
        mem_valid = 1'b1; mem_addr = 32'h8000_0010; slv_ready = 4'b0111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t4_sel", slv_sel, 32'h8);
            chk("t4_ready", mem_ready, 32'h0);
            step();
        end
        chk("t4_err_sel", slv_sel, 32'h0);
        chk("t4_err_ready", mem_ready, 32'h1);
        chk("t4_err_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("t4_err_irq", err_irq, 32'h1);
        chk("t4_err_type", err_type, 32'h2);
        chk("t4_err_addr", err_addr, 32'h8000_0010);
        chk("t4_err_count", err_count, 32'h2);
        mem_valid = 1'b0; slv_ready = 4'b0000;
        step();

        // 300 back-to-back unmapped reads saturate the error counter.
        mem_valid = 1'b1; mem_addr = 32'h4000_0004;
        for (int i = 0; i < 300; i++) begin
            step();
            step();
            if (i == 251) chk("sat_254", err_count, 32'd254);
        end
        mem_valid = 1'b0;
        #1;
        chk("sat_count", err_count, 32'd255);
        chk("sat_type", err_type, 32'h1);
        chk("sat_addr", err_addr, 32'h4000_0004);
        step();

        // Reset asserted while waiting on slave 2.
        mem_valid = 1'b1; mem_addr = 32'h8000_000C;
        step();
        chk("rw_sel", slv_sel, 32'h4);
        reset = 1'b1;
        #1;
        chk("rw_sel_rst", slv_sel, 32'h0);
        chk("rw_ready_rst", mem_ready, 32'h0);
        step();
        reset = 1'b0; mem_valid = 1'b0;
        #1;
        chk("rw_count", err_count, 32'h0);
        chk("rw_type", err_type, 32'h0);
        chk("rw_addr", err_addr, 32'h0);
        chk("rw_irq", err_irq, 32'h0);
        chk("rw_sel_after", slv_sel, 32'h0);
        chk("rw_ready_after", mem_ready, 32'h0);
        chk("rw_rdata_after", mem_rdata, 32'h0);
        mem_valid = 1'b1; mem_addr = 32'h0000_0100; slv_ready = 4'b0001;
        #1;
        chk("rw_idle_sel", slv_sel, 32'h1);
        chk("rw_idle_ready", mem_ready, 32'h1);
        step();
        mem_valid = 1'b0; slv_ready = 4'b0000;

        // Reset asserted during the error cycle.
        mem_valid = 1'b1; mem_addr = 32'h4000_0000;
        step();
        chk("re_irq", err_irq, 32'h1);
        chk("re_count", err_count, 32'h1);
        reset = 1'b1;
        #1;
        chk("re_ready_rst", mem_ready, 32'h0);
        step();
        reset = 1'b0; mem_valid = 1'b0;
        #1;
        chk("re_irq_after", err_irq, 32'h0);
        chk("re_count_after", err_count, 32'h0);
        chk("re_ready_after", mem_ready, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
